// File: rtl/scan_mux.sv
// scan_mux: N-channel, WIDTH-bit registered mux with manual select or round-robin scan.
// Latency: one cycle. Inputs sampled at a rising edge are visible on out/out_ch/out_valid after that edge.
// Backpressure: a word is held while out_valid && !out_ready. Loads happen only when !out_valid || out_ready.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_bus        N packed channels, channel k at in_bus[k*WIDTH +: WIDTH]
//   mode          0 = manual (sel picks the channel), 1 = scan (round-robin from scan_ptr)
//   sel           manual channel select; codes >= N produce no word
//   en_mask       per-channel enable (only when SCAN_MUX_MASK_EN is defined)
//   out, out_ch   registered data and its source channel
//   out_valid     out/out_ch hold a word
//   out_ready     consumer accepts the word this cycle
//
// Build option: define SCAN_MUX_MASK_EN to add en_mask. Masked channels are skipped by the
// scan and invalidate a manual selection. Without it every channel is enabled, and the scan
// becomes a plain increment-with-wrap of scan_ptr.

module scan_mux #(
   parameter int WIDTH = 8,
   parameter int N     = 16,
   parameter int SEL_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   in_bus,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     sel,
`ifdef SCAN_MUX_MASK_EN
   input  logic [N-1:0]         en_mask,
`endif
   output logic [WIDTH-1:0]     out,
   output logic [SEL_W-1:0]     out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   // ------------------------------------------------------------------
   // Internal state
   // ------------------------------------------------------------------
   logic [SEL_W-1:0]  scan_ptr;

   // ------------------------------------------------------------------
   // Combinational selection
   // ------------------------------------------------------------------
   logic              load;        // output stage may take a new word
   logic [N-1:0]      en;          // effective channel enables
   logic              man_ok;      // manual select is in range and enabled
   logic              scan_hit;    // at least one enabled channel exists for the scan
   logic [SEL_W-1:0]  scan_ch;     // first enabled channel at or after scan_ptr
   logic [SEL_W-1:0]  pick;        // channel chosen for this load
   logic              pick_ok;     // chosen channel produces a word
   logic [WIDTH-1:0]  pick_dat;    // data of the chosen channel
   logic [SEL_W-1:0]  ptr_nxt;     // scan pointer after a successful scan load

`ifdef SCAN_MUX_MASK_EN
   logic [2*N-1:0]    en_dbl;      // two copies of the mask, rotated so scan_ptr lands on bit 0
   int                scan_off;    // distance from scan_ptr to the first enabled channel
   int                scan_sum;
`endif

   // out_ready reaches only the register enables through this term.
   assign load = !out_valid || out_ready;

`ifdef SCAN_MUX_MASK_EN
   assign en = en_mask;
`else
   assign en = '1;
`endif

   // Manual select. A code >= N matches no channel, so it leaves man_ok low.
   always_comb begin
      man_ok = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (int'(sel) == k) begin
            man_ok = en[k];
         end
      end
   end

`ifdef SCAN_MUX_MASK_EN
   // Circular priority search. Rotating a doubled copy of the mask right by
   // scan_ptr puts the search origin at bit 0. The lowest set bit in the low N
   // bits is then the nearest enabled channel, counting forward with wrap.
   always_comb begin
      en_dbl   = {en, en} >> scan_ptr;
      scan_hit = 1'b0;
      scan_off = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (en_dbl[i]) begin
            scan_hit = 1'b1;
            scan_off = i;
         end
      end
      scan_sum = int'(scan_ptr) + scan_off;
      if (scan_sum >= N) begin
         scan_sum = scan_sum - N;
      end
      scan_ch = SEL_W'(scan_sum);
   end
`else
   // All channels are enabled. scan_ptr itself is the next channel to emit.
   always_comb begin
      scan_hit = 1'b1;
      scan_ch  = scan_ptr;
   end
`endif

   // Pick the source for this load and fetch its data.
   always_comb begin
      pick     = mode ? scan_ch  : sel;
      pick_ok  = mode ? scan_hit : man_ok;
      pick_dat = '0;
      for (int k = 0; k < N; k++) begin
         if (int'(pick) == k) begin
            pick_dat = in_bus[k*WIDTH +: WIDTH];
         end
      end
   end

   // Advance past the emitted channel. The wrap is explicit at N-1, so codes
   // >= N never reach scan_ptr when N is not a power of two.
   always_comb begin
      if (int'(scan_ch) >= N - 1) begin
         ptr_nxt = '0;
      end else begin
         ptr_nxt = scan_ch + SEL_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Output stage and scan pointer
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         scan_ptr  <= '0;
      end else if (load) begin
         if (pick_ok) begin
            out       <= pick_dat;
            out_ch    <= pick;
            out_valid <= 1'b1;
         end else begin
            // Nothing to emit. The old data and tag stay, but they are marked invalid.
            out_valid <= 1'b0;
         end
         // Manual loads leave the pointer alone, so scanning resumes where it stopped.
         if (mode && scan_hit) begin
            scan_ptr <= ptr_nxt;
         end
      end
   end

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode;
   logic          out_ready;
   logic [3:0]    sel;
   logic [15:0]   en16;
   logic [11:0]   en12;
   logic [127:0]  in16;
   logic [95:0]   in12;

   logic [7:0]    o16, o12;
   logic [3:0]    c16, c12;
   logic          v16, v12;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   scan_mux #(.WIDTH(8), .N(16), .SEL_W(4)) dut16 (
      .clk(clk), .rst(rst), .in_bus(in16), .mode(mode), .sel(sel),
`ifdef SCAN_MUX_MASK_EN
      .en_mask(en16),
`endif
      .out(o16), .out_ch(c16), .out_valid(v16), .out_ready(out_ready)
   );

   scan_mux #(.WIDTH(8), .N(12), .SEL_W(4)) dut12 (
      .clk(clk), .rst(rst), .in_bus(in12), .mode(mode), .sel(sel),
`ifdef SCAN_MUX_MASK_EN
      .en_mask(en12),
`endif
      .out(o12), .out_ch(c12), .out_valid(v12), .out_ready(out_ready)
   );

   // ------------------------------------------------------------------
   // Reference model: index 0 models the N=16 instance, index 1 the N=12 one.
   // ------------------------------------------------------------------
   int m_out [2];
   int m_ch  [2];
   int m_vld [2];
   int m_ptr [2];

   function automatic bit enabled(int d, int c);
`ifdef SCAN_MUX_MASK_EN
      return (d == 0) ? en16[c] : en12[c];
`else
      return 1'b1;
`endif
   endfunction

   function automatic int chan_data(int d, int c);
      return (d == 0) ? int'(in16[c*8 +: 8]) : int'(in12[c*8 +: 8]);
   endfunction

   task automatic model_step(int d);
      int n;
      int c;
      bit ok;
      n = (d == 0) ? 16 : 12;
      c = 0;
      ok = 1'b0;
      if (rst) begin
         m_out[d] = 0; m_ch[d] = 0; m_vld[d] = 0; m_ptr[d] = 0;
      end else if (m_vld[d] == 0 || out_ready) begin
         if (!mode) begin
            c  = int'(sel);
            ok = (c < n) && enabled(d, c);
         end else begin
            for (int i = 0; i < n; i++) begin
               if (!ok && enabled(d, (m_ptr[d] + i) % n)) begin
                  c  = (m_ptr[d] + i) % n;
                  ok = 1'b1;
               end
            end
            if (ok) m_ptr[d] = (c + 1) % n;
         end
         if (ok) begin
            m_out[d] = chan_data(d, c);
            m_ch[d]  = c;
            m_vld[d] = 1;
         end else begin
            m_vld[d] = 0;
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   task automatic check(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("m16.valid", int'(v16), m_vld[0]);
         check("m16.out",   int'(o16), m_out[0]);
         check("m16.ch",    int'(c16), m_ch[0]);
         check("m12.valid", int'(v12), m_vld[1]);
         check("m12.out",   int'(o12), m_out[1]);
         check("m12.ch",    int'(c12), m_ch[1]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ------------------------------------------------------------------
   initial begin
      for (int k = 0; k < 16; k++) in16[k*8 +: 8] = 8'hA0 + 8'(k);
      for (int k = 0; k < 12; k++) in12[k*8 +: 8] = 8'hA0 + 8'(k);
      en16 = 16'hFFFF;
      en12 = 12'hFFF;
      rst = 1'b1;
      mode = 1'($urandom_range(1));
      sel = 4'($urandom_range(15));
      out_ready = 1'($urandom_range(1));

      // Reset with arbitrary inputs.
      step();
      chk_on = 1'b1;
      mode = 1'($urandom_range(1));
      sel = 4'($urandom_range(15));
      step();
      check("rst.out", int'(o16), 0);
      check("rst.ch", int'(c16), 0);
      check("rst.valid", int'(v16), 0);

      // Manual selection.
      rst = 1'b0; mode = 1'b0; out_ready = 1'b1; sel = 4'd5;
      step();
      check("man5.out", int'(o16), 'hA5);
      check("man5.ch", int'(c16), 5);
      check("man5.valid", int'(v16), 1);
      sel = 4'd15;
      step();
      check("man15.out", int'(o16), 'hAF);
      check("man15.ch", int'(c16), 15);
      check("man15.n12.valid", int'(v12), 0);
      sel = 4'd13;
      step();
      check("man13.n12.valid", int'(v12), 0);
      check("man13.out", int'(o16), 'hAD);

      // Scan from reset, including the wrap on both instances.
      rst = 1'b1;
      step();
      rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         step();
         check("scan.ch", int'(c16), k % 16);
         check("scan.out", int'(o16), 'hA0 + (k % 16));
         check("scan.n12.ch", int'(c12), k % 12);
      end

      // Backpressure while out_ch = 3.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) step();
      check("bp.pre.ch", int'(c16), 3);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("bp.hold.ch", int'(c16), 3);
         check("bp.hold.out", int'(o16), 'hA3);
         check("bp.hold.valid", int'(v16), 1);
      end
      out_ready = 1'b1;
      step();
      check("bp.release.ch", int'(c16), 4);
      step();
      check("bp.next.ch", int'(c16), 5);

      // Reset in the middle of a stall drops the pending word.
      out_ready = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("rststall.out", int'(o16), 0);
      check("rststall.ch", int'(c16), 0);
      check("rststall.valid", int'(v16), 0);
      rst = 1'b0; out_ready = 1'b1;

      // Mode switch: scan resumes from the retained pointer.
      step();
      step();
      check("sw.scan1.ch", int'(c16), 1);
      mode = 1'b0; sel = 4'd9;
      step();
      check("sw.man.ch", int'(c16), 9);
      mode = 1'b1;
      step();
      check("sw.resume.ch", int'(c16), 2);
      check("sw.resume.out", int'(o16), 'hA2);

`ifdef SCAN_MUX_MASK_EN
      // Masked scan.
      en16 = 16'h0111; en12 = 12'h111;
      rst = 1'b1;
      step();
      rst = 1'b0; mode = 1'b1;
      step(); check("mask.ch0", int'(c16), 0);
      step(); check("mask.ch4", int'(c16), 4);
      step(); check("mask.ch8", int'(c16), 8);
      step(); check("mask.wrap", int'(c16), 0);
      en16 = 16'h0000; en12 = 12'h000;
      step(); check("mask.none.valid", int'(v16), 0);
      mode = 1'b0; sel = 4'd4; en16 = 16'hFFEF; en12 = 12'hFEF;
      step(); check("mask.man4.valid", int'(v16), 0);
      sel = 4'd5;
      step();
      check("mask.man5.valid", int'(v16), 1);
      check("mask.man5.out", int'(o16), 'hA5);
      en16 = 16'hFFFF; en12 = 12'hFFF;
`endif

      step();
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready output stage. In manual mode it selects one channel; in scan mode it round-robins across channels and tags each output word with its source channel. It is the sequential successor to the combinational 2:1/16:1 mux tree. It sits between a bank of sampled sources and a single serial consumer.

## Interface
- WIDTH, 8: bits per channel.
- N, 16: channel count, 2..256.
- SEL_W, 4: select/tag width; must satisfy 2**SEL_W >= N.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- in_bus  in  N*WIDTH  channel k occupies in_bus[k*WIDTH +: WIDTH].
- mode  in  1  0 = manual, 1 = scan.
- sel  in  SEL_W  manual channel select.
- en_mask  in  N  per-channel enable; present only with SCAN_MUX_MASK_EN.
- out  out  WIDTH  registered data.
- out_ch  out  SEL_W  channel that produced out.
- out_valid  out  1  out/out_ch hold a word.
- out_ready  in  1  consumer accepts the word this cycle.

## Operation
- Internal state: output registers and scan_ptr [SEL_W-1:0].
- Load condition: load = !out_valid || out_ready. No load means stall: out, out_ch, out_valid and scan_ptr all hold, and input changes are ignored.
- Manual load:
  - ch = sel.
  - If sel >= N, or the channel is masked off: out_valid <= 0; out and out_ch hold.
  - Otherwise: out <= in_bus[ch], out_ch <= ch, out_valid <= 1.
  - scan_ptr is untouched in manual mode.
- Scan load:
  - ch = first enabled channel at or after scan_ptr, searching circularly (scan_ptr, scan_ptr+1, …, N-1, 0, …).
  - Load as in manual mode, then scan_ptr <= (ch+1) mod N. Wrap is from N-1 to 0; codes >= N are never produced.
  - No channel enabled: out_valid <= 0, and scan_ptr holds.
- Mode switch: takes effect on the next load. Scan resumes from the retained scan_ptr.
- A word is transferred when out_valid && out_ready. Every accepted word is produced by exactly one load.

## Timing
- Reset values: out = 0, out_ch = 0, out_valid = 0, scan_ptr = 0.
- rst overrides everything, including a mid-stall condition. The pending word is discarded.
- Latency is one cycle: inputs sampled at edge t appear at edge t. They are visible in cycle t+1.
- Throughput is one word per cycle while out_ready stays high.
- In scan mode with all channels enabled and out_ready high, out_ch steps 0,1,…,N-1,0 on consecutive cycles.
- The outputs are registers. No combinational path from in_bus, sel or mode to any output.
- out_ready→load is a combinational path into the register enables only.

## Configuration
- SCAN_MUX_MASK_EN defined:
  - The en_mask port exists.
  - Masked channels are skipped in scan and invalidate manual selection.
  - The circular priority search is N-wide.
- SCAN_MUX_MASK_EN undefined:
  - The en_mask port is absent and all channels are treated as enabled.
  - Scan reduces to scan_ptr increment-with-wrap.
  - out_valid drops only for sel >= N.

## Test plan
All scenarios use N=16, WIDTH=8, SEL_W=4 and in_bus channel k = 8'hA0+k unless stated.
- Reset: rst=1 for 2 cycles with arbitrary inputs -> out=8'h00, out_ch=0, out_valid=0. Repeat with rst asserted during a stall -> same values next cycle.
- Manual: mode=0, out_ready=1, sel=5 -> next cycle out=8'hA5, out_ch=5, out_valid=1. Then sel=15 -> out=8'hAF, out_ch=15.
- Scan wrap: mode=1, out_ready=1, from reset -> out_ch sequence 0..15,0 and out sequence 8'hA0..8'hAF,8'hA0 on consecutive cycles.
- Backpressure: scan, drop out_ready for 3 cycles while out_ch=3 -> out=8'hA3, out_ch=3 held. Raise out_ready -> next cycle out_ch=4, with no channel skipped or repeated.
- Mask (macro on): scan, en_mask=16'h0111 -> out_ch 0,4,8,0. en_mask=16'h0000 -> out_valid=0 from the next load. Manual sel=4 with mask bit 4 clear -> out_valid=0.
- Out-of-range: N=12, SEL_W=4, manual sel=13 -> out_valid=0. Scan -> out_ch 0..11,0 with no tag >= 12.
